pipe_ctrl_regs: RTL and testbench

- Control-side pipeline register chain: ID/EX, EX/MEM and MEM/WB for the 5-stage SCPU pipeline.
- Takes decoded control from the ID-stage decoder, carries it down the pipe, and returns the hazard-unit feedback signals (ewreg, em2reg, ern, mwreg, mm2reg, mrn).
- Applies the decoder's stall decision: holds PC/IF-ID and injects a bubble into EX.
- Applies the branch-flush request.

---
 rtl/pipe_ctrl_regs_if.sv | 84 ++++++++
 rtl/pipe_ctrl_regs.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_regs_if.sv
// Control bundle between the ID-stage decoder/hazard logic and the pipeline
// control register chain.
// master: drives decoded ID control, nostall and flush; observes stage control.
// slave : the register chain; drives PC/IR enables and EX/MEM/WB control.
// Optional: PIPE_PERF_CNT_EN adds the CNT_W parameter and the
//           retired/stall/flush performance counter outputs.
interface pipe_ctrl_regs_if #(
  parameter int unsigned RN_W    = 5,
  parameter int unsigned ALUOP_W = 4
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
);

  // ID-stage decoded control
  logic               d_wreg;
  logic               d_m2reg;
  logic [1:0]         d_wdsel;
  logic               d_mwrite;
  logic [ALUOP_W-1:0] d_aluop;
  logic               d_alusrc;
  logic [1:0]         d_alusrca;
  logic [RN_W-1:0]    d_rn;
  logic               d_valid;
  logic               nostall;
  logic               flush;

  // Front-end enables
  logic               pc_we;
  logic               ir_we;

  // EX stage
  logic [ALUOP_W-1:0] e_aluop;
  logic               e_alusrc;
  logic [1:0]         e_alusrca;
  logic               ewreg;
  logic               em2reg;
  logic [RN_W-1:0]    ern;
  logic               e_valid;

  // MEM stage
  logic               mwreg;
  logic               mm2reg;
  logic               mmwrite;
  logic [RN_W-1:0]    mrn;
  logic               m_valid;

  // WB stage
  logic               wwreg;
  logic [1:0]         wwdsel;
  logic [RN_W-1:0]    wrn;
  logic               w_valid;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]   retired_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
`endif

  modport master (
    output d_wreg, d_m2reg, d_wdsel, d_mwrite, d_aluop, d_alusrc, d_alusrca,
           d_rn, d_valid, nostall, flush,
    input  pc_we, ir_we,
           e_aluop, e_alusrc, e_alusrca, ewreg, em2reg, ern, e_valid,
           mwreg, mm2reg, mmwrite, mrn, m_valid,
           wwreg, wwdsel, wrn, w_valid
`ifdef PIPE_PERF_CNT_EN
         , retired_cnt, stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  d_wreg, d_m2reg, d_wdsel, d_mwrite, d_aluop, d_alusrc, d_alusrca,
           d_rn, d_valid, nostall, flush,
    output pc_we, ir_we,
           e_aluop, e_alusrc, e_alusrca, ewreg, em2reg, ern, e_valid,
           mwreg, mm2reg, mmwrite, mrn, m_valid,
           wwreg, wwdsel, wrn, w_valid
`ifdef PIPE_PERF_CNT_EN
         , retired_cnt, stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_ctrl_regs.sv
// ID/EX, EX/MEM and MEM/WB control register chain for the 5-stage SCPU.
// Ports:
//   clk  - system clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - pipe_ctrl_regs_if.slave: ID control in, nostall/flush in,
//          pc_we/ir_we (combinational) and per-stage control/feedback out.
// Optional: PIPE_PERF_CNT_EN adds wrapping retired/stall/flush counters.
module pipe_ctrl_regs #(
  parameter int unsigned RN_W    = 5,
  parameter int unsigned ALUOP_W = 4
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  pipe_ctrl_regs_if.slave      bus
);

  typedef struct packed {
    logic               wreg;
    logic               m2reg;
    logic [1:0]         wdsel;
    logic               mwrite;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic [1:0]         alusrca;
    logic [RN_W-1:0]    rn;
    logic               valid;
  } ex_t;

  typedef struct packed {
    logic            wreg;
    logic            m2reg;
    logic [1:0]      wdsel;
    logic            mwrite;
    logic [RN_W-1:0] rn;
    logic            valid;
  } mem_t;

  typedef struct packed {
    logic            wreg;
    logic [1:0]      wdsel;
    logic [RN_W-1:0] rn;
    logic            valid;
  } wb_t;

  ex_t  ex_d;
  ex_t  ex_q;
  mem_t mem_q;
  wb_t  wb_q;

  // Front end holds while a load-use stall is requested
  assign bus.pc_we = bus.nostall;
  assign bus.ir_we = bus.nostall;

  // EX entry: a stall, a flush or both insert exactly one all-zero bubble
  always_comb begin
    ex_d = '0;
    if (bus.nostall && !bus.flush) begin
      // A write to r0 is never reported as a pending write
      ex_d.wreg    = bus.d_wreg & (bus.d_rn != '0);
      ex_d.m2reg   = bus.d_m2reg;
      ex_d.wdsel   = bus.d_wdsel;
      ex_d.mwrite  = bus.d_mwrite;
      ex_d.aluop   = bus.d_aluop;
      ex_d.alusrc  = bus.d_alusrc;
      ex_d.alusrca = bus.d_alusrca;
      ex_d.rn      = bus.d_rn;
      ex_d.valid   = bus.d_valid;
    end
  end

  // Stage registers; MEM and WB advance every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q.wreg   <= ex_q.wreg;
      mem_q.m2reg  <= ex_q.m2reg;
      mem_q.wdsel  <= ex_q.wdsel;
      mem_q.mwrite <= ex_q.mwrite;
      mem_q.rn     <= ex_q.rn;
      mem_q.valid  <= ex_q.valid;
      wb_q.wreg    <= mem_q.wreg;
      wb_q.wdsel   <= mem_q.wdsel;
      wb_q.rn      <= mem_q.rn;
      wb_q.valid   <= mem_q.valid;
    end
  end

  assign bus.e_aluop   = ex_q.aluop;
  assign bus.e_alusrc  = ex_q.alusrc;
  assign bus.e_alusrca = ex_q.alusrca;
  assign bus.ewreg     = ex_q.wreg;
  assign bus.em2reg    = ex_q.m2reg;
  assign bus.ern       = ex_q.rn;
  assign bus.e_valid   = ex_q.valid;

  assign bus.mwreg     = mem_q.wreg;
  assign bus.mm2reg    = mem_q.m2reg;
  assign bus.mmwrite   = mem_q.mwrite;
  assign bus.mrn       = mem_q.rn;
  assign bus.m_valid   = mem_q.valid;

  assign bus.wwreg     = wb_q.wreg;
  assign bus.wwdsel    = wb_q.wdsel;
  assign bus.wrn       = wb_q.rn;
  assign bus.w_valid   = wb_q.valid;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Free-running counters, wrap on overflow; a flush masked by a stall is not counted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(wb_q.valid);
      stall_q   <= stall_q + CNT_W'(!bus.nostall);
      flush_q   <= flush_q + CNT_W'(bus.flush & bus.nostall);
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: directed vector table, async reset
// sequences and randomized traffic against a cycle-history reference model.
module tb_pipe_ctrl_regs;

  localparam int unsigned RN_W    = 5;
  localparam int unsigned ALUOP_W = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam int unsigned CNT_W   = 4;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_ctrl_regs_if #(
    .RN_W(RN_W), .ALUOP_W(ALUOP_W)
`ifdef PIPE_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  pipe_ctrl_regs #(
    .RN_W(RN_W), .ALUOP_W(ALUOP_W)
`ifdef PIPE_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [1:0] wdsel;
    logic       mwrite;
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] alusrca;
    logic [4:0] rn;
    logic       valid;
  } instr_t;

  // Stage view {write-enable, rn, valid}
  typedef struct {
    instr_t     ins;
    logic       ns;
    logic       fl;
    logic [6:0] e;
    logic [6:0] m;
    logic [6:0] w;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: instruction that entered EX on each of the last 3 edges
  instr_t hist[3];
  int     m_ret, m_stl, m_fls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic instr_t mk(input logic wreg, input logic m2reg, input logic [1:0] wdsel,
                                input logic mwrite, input logic [3:0] aluop,
                                input logic [4:0] rn, input logic valid);
    instr_t i;
    i = '0;
    i.wreg = wreg; i.m2reg = m2reg; i.wdsel = wdsel; i.mwrite = mwrite;
    i.aluop = aluop; i.rn = rn; i.valid = valid;
    i.alusrc = aluop[0]; i.alusrca = aluop[2:1];
    return i;
  endfunction

  function automatic logic [6:0] st(input logic w, input logic [4:0] rn, input logic v);
    return {w, rn, v};
  endfunction

  function automatic logic gated(input instr_t i);
    return i.wreg && (i.rn != 5'd0);
  endfunction

  task automatic drive(input instr_t i, input logic ns, input logic fl);
    bus.d_wreg = i.wreg; bus.d_m2reg = i.m2reg; bus.d_wdsel = i.wdsel;
    bus.d_mwrite = i.mwrite; bus.d_aluop = i.aluop; bus.d_alusrc = i.alusrc;
    bus.d_alusrca = i.alusrca; bus.d_rn = i.rn; bus.d_valid = i.valid;
    bus.nostall = ns; bus.flush = fl;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_ret = 0; m_stl = 0; m_fls = 0;
  endtask

  task automatic model_step(input instr_t i, input logic ns, input logic fl);
    if (!rstn) begin
      model_clear();
    end else begin
      if (hist[2].valid) m_ret++;
      if (!ns) m_stl++;
      if (fl && ns) m_fls++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (ns && !fl) ? i : instr_t'('0);
    end
  endtask

  task automatic check_model();
    check("model_ex",
      32'({bus.e_aluop, bus.e_alusrc, bus.e_alusrca, bus.ewreg, bus.em2reg, bus.ern, bus.e_valid}),
      32'({hist[0].aluop, hist[0].alusrc, hist[0].alusrca, gated(hist[0]), hist[0].m2reg,
           hist[0].rn, hist[0].valid}));
    check("model_mem",
      32'({bus.mwreg, bus.mm2reg, bus.mmwrite, bus.mrn, bus.m_valid}),
      32'({gated(hist[1]), hist[1].m2reg, hist[1].mwrite, hist[1].rn, hist[1].valid}));
    check("model_wb",
      32'({bus.wwreg, bus.wwdsel, bus.wrn, bus.w_valid}),
      32'({gated(hist[2]), hist[2].wdsel, hist[2].rn, hist[2].valid}));
`ifdef PIPE_PERF_CNT_EN
    check("model_retired_cnt", 32'(bus.retired_cnt), 32'(m_ret % 16));
    check("model_stall_cnt",   32'(bus.stall_cnt),   32'(m_stl % 16));
    check("model_flush_cnt",   32'(bus.flush_cnt),   32'(m_fls % 16));
`endif
  endtask

  task automatic cycle(input instr_t i, input logic ns, input logic fl);
    drive(i, ns, fl);
    #1;
    check("pc_we", 32'(bus.pc_we), 32'(ns));
    check("ir_we", 32'(bus.ir_we), 32'(ns));
    @(posedge clk);
    model_step(i, ns, fl);
    #1;
    check_model();
  endtask

  task automatic check_zero(input string name);
    check(name,
      32'({bus.e_aluop, bus.e_alusrc, bus.e_alusrca, bus.ewreg, bus.em2reg, bus.ern, bus.e_valid,
           bus.mwreg, bus.mm2reg, bus.mmwrite}), 32'd0);
    check({name, "_mw"},
      32'({bus.mrn, bus.m_valid, bus.wwreg, bus.wwdsel, bus.wrn, bus.w_valid}), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check({name, "_cnt"}, 32'({bus.retired_cnt, bus.stall_cnt, bus.flush_cnt}), 32'd0);
`endif
  endtask

  // Async assertion mid-stream during a stall, then release away from the edge
  task automatic async_reset();
    instr_t busy;
    busy = mk(1'b1, 1'b0, 2'd1, 1'b0, 4'd3, 5'd12, 1'b1);
    drive(busy, 1'b0, 1'b0);
    #3 rstn = 1'b0;
    #1;
    check_zero("async_rst");
    check("rst_pc_we_stall", 32'(bus.pc_we), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    check_zero("rst_held");
    drive(busy, 1'b1, 1'b0);
    #1;
    check("rst_pc_we_follow", 32'(bus.pc_we), 32'd1);
    #2 rstn = 1'b1;
  endtask

  vec_t   tbl[22];
  instr_t idle;
  instr_t ri;
  logic [31:0] r;

  initial begin
    idle = '0;
    tbl[0]  = '{mk(1,0,0,0,4'd1,5'd8,1),  1'b1, 1'b0, st(1,8,1),  7'd0,       7'd0};
    tbl[1]  = '{idle,                      1'b1, 1'b0, 7'd0,       st(1,8,1),  7'd0};
    tbl[2]  = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       st(1,8,1)};
    tbl[3]  = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       7'd0};
    tbl[4]  = '{mk(1,1,1,0,4'd2,5'd9,1),  1'b1, 1'b0, st(1,9,1),  7'd0,       7'd0};
    tbl[5]  = '{mk(1,0,0,1,4'd3,5'd10,1), 1'b0, 1'b0, 7'd0,       st(1,9,1),  7'd0};
    tbl[6]  = '{mk(1,0,0,1,4'd3,5'd10,1), 1'b1, 1'b0, st(1,10,1), 7'd0,       st(1,9,1)};
    tbl[7]  = '{idle,                      1'b1, 1'b0, 7'd0,       st(1,10,1), 7'd0};
    tbl[8]  = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       st(1,10,1)};
    tbl[9]  = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       7'd0};
    tbl[10] = '{mk(1,0,0,0,4'd1,5'd0,1),  1'b1, 1'b0, st(0,0,1),  7'd0,       7'd0};
    tbl[11] = '{idle,                      1'b1, 1'b0, 7'd0,       st(0,0,1),  7'd0};
    tbl[12] = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       st(0,0,1)};
    tbl[13] = '{mk(1,0,2,0,4'd4,5'd3,1),  1'b0, 1'b1, 7'd0,       7'd0,       7'd0};
    tbl[14] = '{mk(1,0,2,0,4'd4,5'd3,1),  1'b1, 1'b0, st(1,3,1),  7'd0,       7'd0};
    tbl[15] = '{mk(1,0,0,0,4'd5,5'd4,1),  1'b1, 1'b1, 7'd0,       st(1,3,1),  7'd0};
    tbl[16] = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       st(1,3,1)};
    tbl[17] = '{mk(1,0,0,0,4'd6,5'd5,1),  1'b0, 1'b0, 7'd0,       7'd0,       7'd0};
    tbl[18] = '{mk(1,0,0,0,4'd6,5'd5,1),  1'b0, 1'b0, 7'd0,       7'd0,       7'd0};
    tbl[19] = '{mk(1,0,0,0,4'd6,5'd5,1),  1'b1, 1'b0, st(1,5,1),  7'd0,       7'd0};
    tbl[20] = '{idle,                      1'b1, 1'b0, 7'd0,       st(1,5,1),  7'd0};
    tbl[21] = '{idle,                      1'b1, 1'b0, 7'd0,       7'd0,       st(1,5,1)};

    // Power-on reset; enables track nostall while reset is held
    rstn = 1'b0;
    drive(idle, 1'b1, 1'b0);
    model_clear();
    #2;
    check_zero("por");
    check("por_pc_we", 32'(bus.pc_we), 32'd1);
    #10 rstn = 1'b1;

    // Directed vectors
    for (int v = 0; v < 22; v++) begin
      cycle(tbl[v].ins, tbl[v].ns, tbl[v].fl);
      check($sformatf("vec%0d_ex", v),  32'({bus.ewreg, bus.ern, bus.e_valid}), 32'(tbl[v].e));
      check($sformatf("vec%0d_mem", v), 32'({bus.mwreg, bus.mrn, bus.m_valid}), 32'(tbl[v].m));
      check($sformatf("vec%0d_wb", v),  32'({bus.wwreg, bus.wrn, bus.w_valid}), 32'(tbl[v].w));
    end

    // Reset mid-stream with all stages busy, then first instruction latency
    cycle(mk(1,0,1,0,4'd7,5'd20,1), 1'b1, 1'b0);
    cycle(mk(1,1,1,0,4'd8,5'd21,1), 1'b1, 1'b0);
    cycle(mk(1,0,0,1,4'd9,5'd22,1), 1'b1, 1'b0);
    async_reset();
    cycle(mk(1,0,1,0,4'd2,5'd7,1), 1'b1, 1'b0);
    check("rst_first_ex", 32'({bus.ewreg, bus.ern, bus.e_valid}), 32'(st(1,7,1)));
    cycle(idle, 1'b1, 1'b0);
    cycle(idle, 1'b1, 1'b0);
    check("rst_first_wb", 32'({bus.wwreg, bus.wrn, bus.w_valid}), 32'(st(1,7,1)));

`ifdef PIPE_PERF_CNT_EN
    // Retired counter wraps: 17 retirements in a 4-bit counter leave 1
    @(posedge clk); #1;
    async_reset();
    for (int n = 0; n < 17; n++) cycle(mk(1,0,0,0,4'd1,5'(n + 1),1), 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) cycle(idle, 1'b1, 1'b0);
    check("retired_wrap", 32'(bus.retired_cnt), 32'd1);
`endif

    // Randomized traffic with one more mid-stream reset
    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      ri = r[$bits(instr_t)-1:0];
      if ($urandom_range(0, 3) == 0) ri.rn = 5'd0;
      if (n == 200) async_reset();
      cycle(ri, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
